// File: rtl/alu_out_skid.sv
// Registered output stage behind the 16-bit ALU: a 2-entry skid buffer carrying
// {word, zr, ng} with a fully registered in_ready and 1 word/cycle throughput.
module alu_out_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_out,
    input  logic             in_zr,
    input  logic             in_ng,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [WIDTH-1:0]   main_word;
    logic               main_zr;
    logic               main_ng;
    logic [WIDTH-1:0]   skid_word;
    logic               skid_zr;
    logic               skid_ng;

    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    logic               out_valid_q;
    logic               in_ready_q;
    logic [1:0]         count_q;

    // Next-state and load selects; the input is only looked at when the state allows it.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load_main_in = 1'b1;
                    next_state   = BUSY;
                end
            end
            BUSY: begin
                if (in_valid && out_ready) begin
                    load_main_in = 1'b1;
                end else if (in_valid && !out_ready) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (!in_valid && out_ready) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_main_skid = 1'b1;
                    next_state     = BUSY;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Main entry drives the outputs; it keeps its last value when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_word <= '0;
            main_zr   <= 1'b0;
            main_ng   <= 1'b0;
        end else if (load_main_in) begin
            main_word <= in_out;
            main_zr   <= in_zr;
            main_ng   <= in_ng;
        end else if (load_main_skid) begin
            main_word <= skid_word;
            main_zr   <= skid_zr;
            main_ng   <= skid_ng;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_word <= '0;
            skid_zr   <= 1'b0;
            skid_ng   <= 1'b0;
        end else if (load_skid) begin
            skid_word <= in_out;
            skid_zr   <= in_zr;
            skid_ng   <= in_ng;
        end
    end

    // Handshake outputs are flops fed from next_state so nothing reaches back combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            out_valid_q <= (next_state != EMPTY);
            in_ready_q  <= (next_state != FULL);
            case (next_state)
                EMPTY:   count_q <= 2'd0;
                BUSY:    count_q <= 2'd1;
                FULL:    count_q <= 2'd2;
                default: count_q <= 2'd0;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign count     = count_q;
    assign out       = main_word;
    assign zr        = main_zr;
    assign ng        = main_ng;

endmodule

// File: doc/alu_out_skid.md
Name: alu_out_skid

Overview:
- Registered output stage directly downstream of the 16-bit ALU datapath (And16/Or16/Not16/Add16 network).
- Captures the ALU result word and its zr/ng flags behind a valid/ready handshake.
- 2-entry skid buffer: full throughput (1 word/cycle), in_ready fully registered, so the next consumer (D/A register load, memory write path) can stall without a combinational ready path back into the ALU.

Parameters:
- WIDTH, 16, data word width (ALU word size).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept; registered.
- in_out  input  WIDTH  ALU result word.
- in_zr  input  1  ALU zero flag.
- in_ng  input  1  ALU negative flag.
- out_valid  output  1  registered result valid.
- out_ready  input  1  consumer accepts.
- out  output  WIDTH  registered result word.
- zr  output  1  registered zero flag.
- ng  output  1  registered negative flag.
- count  output  2  occupancy 0..2 (debug/verification).

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out=0, zr=0, ng=0, in_ready=1, count=0, skid regs=0, state=EMPTY. Takes effect immediately, independent of clk.
- Reset asserted mid-transfer discards all held words. No partial state survives.
- Transfer rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Entry storage: the main register drives out/zr/ng; the skid register holds one overflow entry. Each entry is {word, zr, ng}, carried unchanged (no recomputation).
- States, with count = 0/1/2:
  - EMPTY: out_valid=0, in_ready=1.
    - in_valid -> main<=input, BUSY.
    - else stay.
  - BUSY: out_valid=1, in_ready=1.
    - in_valid & out_ready -> main<=input, stay BUSY.
    - in_valid & !out_ready -> skid<=input, FULL.
    - !in_valid & out_ready -> EMPTY.
    - neither -> hold.
  - FULL: out_valid=1, in_ready=0, in_valid ignored.
    - out_ready -> main<=skid, BUSY.
    - else hold.
- Latency: word accepted at edge N appears on out with out_valid=1 after edge N (EMPTY case). Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering: strict FIFO. No loss, no duplication.
- Stability: while out_valid=1 & out_ready=0, out/zr/ng/out_valid must not change.
- in_ready depends only on registered state, never combinationally on out_ready.
- out/zr/ng hold their last value when out_valid=0. The value is don't-care to consumers but must not be X after reset.
- Illegal input (in_valid while in_ready=0) is ignored; the data is not captured.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_out=0xFFFF -> out_valid=0, in_ready=1, out=0x0000, count=0. Deassert rst_n -> first capture on next edge.
- Single word: in_out=0x1034 (0x1234 AND 0x9876), zr=0, ng=0, out_ready=1 -> one edge later out=0x1034, out_valid=1. Following cycle out_valid=0 when no new input.
- Streaming: 6 back-to-back words 0x0000, 0x0000, 0xFFFF, 0x0000, 0x0CC0, 0x1034 with matching flags (zr=1 for 0x0000, ng=1 for 0xFFFF), out_ready=1 -> same sequence out on 6 consecutive cycles, count never exceeds 1.
- Stall/skid: out_ready=0, send 0xAAAA then 0x5555 -> count=2, in_ready=0. Third word 0x1111 offered is ignored. out_ready=1 -> outputs 0xAAAA, then 0x5555, in_ready returns 1 the cycle after the first drain.
- Hold stability: out_valid=1, out_ready=0 for 10 cycles with in_valid toggling -> out, zr, ng unchanged each cycle.
- Async reset mid-operation: in FULL, pulse rst_n low between clock edges -> out_valid and count drop to 0 before the next edge. Both held words are lost and never appear at the output.
